and_gate_self_test_seq: RTL
===========================

Name: and_gate_self_test_seq

Overview:
Self-test sequencer for the And_Gate_Project datapath. On a start pulse it steps the switch vector through every input combination, waits a settle time, samples the LED output and compares it to the expected AND, then holds for a dwell period. It reports per-vector failures, an error count and a pass/done status. It sits between board-level start logic and the gate's sw/led ports, replacing manual switch toggling.

Parameters:
NUM_INPUTS, 2, width of the switch vector driven into the gate (1..4)
SETTLE_CYCLES, 2, cycles the vector is applied before sampling (>=1)
DWELL_CYCLES, 10, cycles the vector is held after sampling (>=1)

Ports:
i_Clk  in  1  system clock, all state on rising edge
i_Rst  in  1  asynchronous, active-high reset
i_Start  in  1  start request, sampled only in IDLE
i_Led  in  1  gate output under test
o_Sw  out  NUM_INPUTS  vector driven to gate sw
o_Busy  out  1  high in every state except IDLE
o_Done  out  1  one-cycle pulse at end of sweep
o_Pass  out  1  1 when the last completed sweep had zero errors
o_Fail_Vec  out  2**NUM_INPUTS  bit k set if vector k mismatched
o_Err_Count  out  $clog2(2**NUM_INPUTS+1)  number of mismatching vectors

Behaviour:
- Reset (async, immediate, any state): state=IDLE, o_Sw=0, o_Busy=0, o_Done=0, o_Pass=0, o_Fail_Vec=0, o_Err_Count=0, internal vec=0, cnt=0.
- States: IDLE, APPLY, CHECK, HOLD, DONE.
- IDLE: o_Sw=0. If i_Start=1: clear o_Fail_Vec, o_Err_Count and o_Pass, set vec=0 and cnt=0, then go to APPLY.
- APPLY: o_Sw=vec. cnt increments each cycle. When cnt==SETTLE_CYCLES-1, clear cnt and go to CHECK.
- CHECK: exactly one cycle with o_Sw=vec. Expected=&vec. If i_Led!=expected, set o_Fail_Vec[vec] and increment o_Err_Count. Go to HOLD with cnt=0.
- HOLD: o_Sw=vec. When cnt==DWELL_CYCLES-1:
  - if vec==all-ones, go to DONE;
  - otherwise increment vec, clear cnt and go to APPLY.
- DONE: one cycle. o_Done=1 and o_Pass=(o_Fail_Vec==0), registered on entry. Next state is IDLE.
- Results persist: o_Pass, o_Fail_Vec and o_Err_Count hold until the next accepted start or reset.
- Timing: per vector = SETTLE_CYCLES+1+DWELL_CYCLES cycles. Full sweep = 2**NUM_INPUTS × that.
  - Defaults: 13 cycles per vector, 52-cycle sweep. o_Done is asserted in the 53rd cycle after the start-accept edge.
- i_Start while o_Busy=1 is ignored (no restart, no clear). i_Start held high through DONE starts a new sweep from IDLE on the following edge.
- i_Led is assumed synchronous to i_Clk (combinational gate path). No synchroniser is included.
- vec never wraps: the terminal compare precedes the increment.
- o_Err_Count saturation is not needed; its width covers 2**NUM_INPUTS.
- Reset mid-sweep discards partial results. o_Sw returns to 0 asynchronously.

Decomposition:
- Package and_seq_pkg holds:
  - state enum (IDLE, APPLY, CHECK, HOLD, DONE);
  - function expected_and(vec) returning &vec;
  - localparams for vector count and counter widths: cnt width $clog2(max(SETTLE_CYCLES,DWELL_CYCLES)).
- Single module, no sub-module. The cnt timer is shared between APPLY and HOLD.

Test Plan:
- Good gate model (i_Led=&o_Sw), start at t0 -> o_Sw sequence 00,01,10,11 each held 13 cycles. o_Done pulses 53 cycles after start-accept. o_Pass=1, o_Fail_Vec=4'b0000, o_Err_Count=0.
- i_Led stuck at 1 -> o_Fail_Vec=4'b0111, o_Err_Count=3, o_Pass=0.
- i_Led stuck at 0 -> o_Fail_Vec=4'b1000, o_Err_Count=1, o_Pass=0.
- Inverted gate (i_Led=~&o_Sw) -> o_Fail_Vec=4'b1111, o_Err_Count=4.
- Good gate, i_Start pulsed again at cycle 20 of the sweep -> ignored. Sweep finishes at cycle 53 with o_Pass=1.
- i_Rst asserted at cycle 30 (vec=2) -> same cycle: o_Sw=0, o_Busy=0, results cleared. A new start gives a full 52-cycle sweep ending in o_Pass=1.

Source files
------------

// File: rtl/and_seq_pkg.sv
// and_seq_pkg: shared states and helpers for the AND gate self-test sequencer
package and_seq_pkg;
   typedef enum logic [2:0] {IDLE, APPLY, CHECK, HOLD, DONE} state_t;
   localparam int MAX_INPUTS = 4;
   function automatic logic expected_and(input logic [MAX_INPUTS-1:0] v, input int n);
      logic r;
      r = 1'b1;
      for (int i = 0; i < MAX_INPUTS; i++)
         if (i < n) r = r & v[i];
      return r;
   endfunction
   function automatic int cnt_width(input int s, input int d);
      int m;
      m = (s > d) ? s : d;
      return (m > 1) ? $clog2(m) : 1;
   endfunction
endpackage

// File: rtl/and_gate_self_test_seq.sv
// and_gate_self_test_seq: sweeps every switch vector into the gate and checks the LED against AND
module and_gate_self_test_seq
   import and_seq_pkg::*;
#(
   parameter int NUM_INPUTS    = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int DWELL_CYCLES  = 10
) (
   input  logic                                 i_Clk,
   input  logic                                 i_Rst,
   input  logic                                 i_Start,
   input  logic                                 i_Led,
   output logic [NUM_INPUTS-1:0]                o_Sw,
   output logic                                 o_Busy,
   output logic                                 o_Done,
   output logic                                 o_Pass,
   output logic [2**NUM_INPUTS-1:0]             o_Fail_Vec,
   output logic [$clog2(2**NUM_INPUTS+1)-1:0]   o_Err_Count
);
   localparam int NV = 2**NUM_INPUTS;
   localparam int EW = $clog2(NV+1);
   localparam int CW = cnt_width(SETTLE_CYCLES, DWELL_CYCLES);
   state_t state, state_n;
   logic [NUM_INPUTS-1:0] vec, vec_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [NV-1:0] fail_n;
   logic [EW-1:0] err_n;
   logic pass_n, done_n;
   assign o_Busy = state != IDLE;
   assign o_Sw   = (state == APPLY || state == CHECK || state == HOLD) ? vec : '0;
   always_comb begin
      state_n = state;
      vec_n   = vec;
      cnt_n   = cnt;
      fail_n  = o_Fail_Vec;
      err_n   = o_Err_Count;
      pass_n  = o_Pass;
      done_n  = 1'b0;
      case (state)
         IDLE: if (i_Start) begin
            fail_n  = '0;
            err_n   = '0;
            pass_n  = 1'b0;
            vec_n   = '0;
            cnt_n   = '0;
            state_n = APPLY;
         end
         APPLY: if (cnt == CW'(SETTLE_CYCLES-1)) begin
            cnt_n   = '0;
            state_n = CHECK;
         end else cnt_n = cnt + 1'b1;
         CHECK: begin
            if (i_Led != expected_and(MAX_INPUTS'(vec), NUM_INPUTS)) begin
               fail_n[vec] = 1'b1;
               err_n       = o_Err_Count + 1'b1;
            end
            cnt_n   = '0;
            state_n = HOLD;
         end
         HOLD: if (cnt == CW'(DWELL_CYCLES-1)) begin
            cnt_n = '0;
            // terminal compare precedes the increment so vec never wraps
            if (&vec) begin
               state_n = DONE;
               done_n  = 1'b1;
               pass_n  = ~|o_Fail_Vec;
            end else begin
               vec_n   = vec + 1'b1;
               state_n = APPLY;
            end
         end else cnt_n = cnt + 1'b1;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) begin
         state       <= IDLE;
         vec         <= '0;
         cnt         <= '0;
         o_Fail_Vec  <= '0;
         o_Err_Count <= '0;
         o_Pass      <= 1'b0;
         o_Done      <= 1'b0;
      end else begin
         state       <= state_n;
         vec         <= vec_n;
         cnt         <= cnt_n;
         o_Fail_Vec  <= fail_n;
         o_Err_Count <= err_n;
         o_Pass      <= pass_n;
         o_Done      <= done_n;
      end
endmodule
